// File: rtl/uart_loader.sv
// Serial boot loader: receives a little-endian word count and data words over 8N1 UART,
// writes them to memory from address 0, then releases the CPU from reset.
module uart_loader #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_rx,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        cpu_resetn,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WORD_W = 32;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {HDR, DATA, WRITE, DONE, ERR} ld_state_t;

  assign mem_instr = 1'b0;

  // Two-flop synchronizer plus one history flop for start-edge detection
  logic rx_s1, rx_s2, rx_prev;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             byte_valid, byte_valid_n;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
      byte_valid <= byte_valid_n;
    end
  end

  // Receiver: mid-bit sampling; a false start or a bad stop bit yields no byte
  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt;
    rx_bit_n     = rx_bit;
    rx_shift_n   = rx_shift;
    byte_valid_n = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_state_n = RX_START;
          rx_cnt_n   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - CNT_W'(1);
        end else if (rx_s2) begin
          rx_state_n = RX_IDLE;
        end else begin
          rx_state_n = RX_BITS;
          rx_cnt_n   = BIT_LOAD;
          rx_bit_n   = 3'd0;
        end
      end
      RX_BITS: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - CNT_W'(1);
        end else begin
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_cnt_n   = BIT_LOAD;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - CNT_W'(1);
        end else begin
          rx_state_n   = RX_IDLE;
          byte_valid_n = rx_s2;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  ld_state_t         state, state_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [23:0]       word, word_n;
  logic [WORD_W-1:0] count, count_n;
  logic [WORD_W-1:0] idx, idx_n;
  logic [WORD_W-1:0] asm_word, idx_inc;
  logic              mem_valid_n, cpu_resetn_n, load_done_n, load_err_n;
  logic [31:0]       mem_addr_n, mem_wdata_n;
  logic [3:0]        mem_wstrb_n;

  assign asm_word = {rx_shift, word};
  assign idx_inc  = idx + WORD_W'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= HDR;
      byte_cnt   <= '0;
      word       <= '0;
      count      <= '0;
      idx        <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      cpu_resetn <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_n;
      byte_cnt   <= byte_cnt_n;
      word       <= word_n;
      count      <= count_n;
      idx        <= idx_n;
      mem_valid  <= mem_valid_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      mem_wstrb  <= mem_wstrb_n;
      cpu_resetn <= cpu_resetn_n;
      load_done  <= load_done_n;
      load_err   <= load_err_n;
    end
  end

  // Loader: bytes shift in from the top so the first byte lands in bits 7:0
  always_comb begin
    state_n      = state;
    byte_cnt_n   = byte_cnt;
    word_n       = word;
    count_n      = count;
    idx_n        = idx;
    mem_valid_n  = mem_valid;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    mem_wstrb_n  = mem_wstrb;
    cpu_resetn_n = cpu_resetn;
    load_done_n  = load_done;
    load_err_n   = load_err;
    case (state)
      HDR: begin
        if (byte_valid) begin
          word_n     = asm_word[31:8];
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            count_n = asm_word;
            if (asm_word == '0) begin
              state_n      = DONE;
              load_done_n  = 1'b1;
              cpu_resetn_n = 1'b1;
            end else if (asm_word > WORD_W'(MAX_WORDS)) begin
              state_n    = ERR;
              load_err_n = 1'b1;
            end else begin
              state_n = DATA;
            end
          end
        end
      end
      DATA: begin
        if (byte_valid) begin
          word_n     = asm_word[31:8];
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            state_n     = WRITE;
            mem_valid_n = 1'b1;
            mem_addr_n  = idx << 2;
            mem_wdata_n = asm_word;
            mem_wstrb_n = 4'hF;
          end
        end
      end
      WRITE: begin
        if (byte_valid) begin
          state_n     = ERR;
          load_err_n  = 1'b1;
          mem_valid_n = 1'b0;
          mem_wstrb_n = 4'h0;
        end else if (mem_ready) begin
          mem_valid_n = 1'b0;
          mem_wstrb_n = 4'h0;
          idx_n       = idx_inc;
          if (idx_inc < count) begin
            state_n = DATA;
          end else begin
            state_n      = DONE;
            load_done_n  = 1'b1;
            cpu_resetn_n = 1'b1;
          end
        end
      end
      DONE: begin
        load_done_n  = 1'b1;
        cpu_resetn_n = 1'b1;
      end
      ERR: begin
        load_err_n   = 1'b1;
        cpu_resetn_n = 1'b0;
        mem_valid_n  = 1'b0;
        mem_wstrb_n  = 4'h0;
      end
      default: state_n = HDR;
    endcase
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: UART byte driver, memory responder with a
// scoreboard of expected writes, and checks on flags and reset behaviour.
module tb_uart_loader;

  localparam int unsigned CLK_DIV   = 16;
  localparam int unsigned MAX_WORDS = 256;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        uart_rx = 1'b1;
  logic        mem_valid, mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        cpu_resetn, load_done, load_err;

  int errors = 0;
  int checks = 0;

  logic [63:0]  exp_q[$];
  int unsigned  ready_delay = 0;
  int unsigned  wait_cnt = 0;
  bit           in_write = 1'b0;
  bit           hs_prev = 1'b0;
  int           writes_started = 0;
  logic [31:0]  cap_addr, cap_data;

  uart_loader #(.CLK_DIV(CLK_DIV), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .resetn(resetn), .uart_rx(uart_rx),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .cpu_resetn(cpu_resetn), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: pops the scoreboard per write, holds off mem_ready by ready_delay
  always @(negedge clk) begin
    logic [63:0] e;
    if (hs_prev) begin
      check("valid_drop_after_ready", 32'(mem_valid), 32'd0);
      if (exp_q.size() == 0) begin
        check("done_after_last_ready", 32'(load_done), 32'd1);
        check("cpu_run_after_last_ready", 32'(cpu_resetn), 32'd1);
      end else begin
        check("not_done_mid_image", 32'(load_done), 32'd0);
      end
    end
    hs_prev = 1'b0;
    if (mem_valid === 1'b1) begin
      if (!in_write) begin
        in_write = 1'b1;
        wait_cnt = 0;
        writes_started++;
        cap_addr = mem_addr;
        cap_data = mem_wdata;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(mem_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", mem_addr, e[63:32]);
          check("write_data", mem_wdata, e[31:0]);
        end
      end else begin
        check("addr_stable", mem_addr, cap_addr);
        check("wdata_stable", mem_wdata, cap_data);
      end
      check("wstrb_during_valid", 32'(mem_wstrb), 32'hF);
      check("instr_zero", 32'(mem_instr), 32'd0);
      mem_ready = (wait_cnt >= ready_delay);
      hs_prev = mem_ready;
      wait_cnt++;
    end else begin
      in_write  = 1'b0;
      mem_ready = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CLK_DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    check({tag, "_cpu_resetn"}, 32'(cpu_resetn), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_err"}, 32'(load_err), 32'd0);
    check({tag, "_mem_instr"}, 32'(mem_instr), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs(tag);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;

    // Reset state
    do_reset("reset");

    // Two-word image with a framing-error byte and a short glitch in the data stream
    ready_delay = 0;
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    exp_q.push_back({32'h0000_0004, 32'h1234_5678});
    send_word(32'd2);
    check("cpu_held_after_header", 32'(cpu_resetn), 32'd0);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'h55, 1'b0);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    ready_delay = 3;
    send_word(32'h1234_5678);
    for (int i = 0; i < 200 && load_done !== 1'b1; i++) @(negedge clk);
    check("load2_done", 32'(load_done), 32'd1);
    check("load2_cpu_run", 32'(cpu_resetn), 32'd1);
    check("load2_no_err", 32'(load_err), 32'd0);
    check("load2_writes", 32'(writes_started), 32'd2);
    send_word(32'd1);
    check("done_ignores_rx_writes", 32'(writes_started), 32'd2);
    check("done_sticky", 32'(load_done), 32'd1);

    // Zero-length image
    do_reset("reset_b");
    base = writes_started;
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check("hdr0_cpu_held_before_last", 32'(cpu_resetn), 32'd0);
    send_byte(8'h00, 1'b1);
    check("hdr0_done", 32'(load_done), 32'd1);
    check("hdr0_cpu_run", 32'(cpu_resetn), 32'd1);
    check("hdr0_no_err", 32'(load_err), 32'd0);
    check("hdr0_no_write", 32'(writes_started), 32'(base));

    // Oversize header
    do_reset("reset_c");
    send_word(32'(MAX_WORDS + 1));
    check("oversize_err", 32'(load_err), 32'd1);
    check("oversize_cpu_held", 32'(cpu_resetn), 32'd0);
    check("oversize_not_done", 32'(load_done), 32'd0);
    send_word(32'd1);
    send_word(32'h0BAD_0BAD);
    check("oversize_err_sticky", 32'(load_err), 32'd1);
    check("oversize_cpu_still_held", 32'(cpu_resetn), 32'd0);
    check("oversize_no_write", 32'(writes_started), 32'(base));

    // Largest legal header is accepted: no error after it
    do_reset("reset_d");
    send_word(32'(MAX_WORDS));
    check("max_words_no_err", 32'(load_err), 32'd0);
    check("max_words_not_done", 32'(load_done), 32'd0);

    // Slow memory, then reset while a write waits for mem_ready
    do_reset("reset_e");
    base = writes_started;
    ready_delay = 7;
    exp_q.push_back({32'h0000_0000, 32'hA5A5_1234});
    exp_q.push_back({32'h0000_0004, 32'h0BAD_F00D});
    send_word(32'd2);
    send_word(32'hA5A5_1234);
    ready_delay = 1000;
    send_word(32'h0BAD_F00D);
    for (int i = 0; i < 200 && writes_started < base + 2; i++) @(negedge clk);
    check("slow_second_write_started", 32'(writes_started), 32'(base + 2));
    repeat (4) @(negedge clk);
    check("slow_still_waiting", 32'(mem_valid), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check_reset_outputs("midwrite_reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Overrun: a byte arrives while a write is pending
    base = writes_started;
    exp_q.push_back({32'h0000_0000, 32'hCAFE_F00D});
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    check("overrun_write_started", 32'(writes_started), 32'(base + 1));
    send_byte(8'h11, 1'b1);
    check("overrun_err", 32'(load_err), 32'd1);
    check("overrun_valid_dropped", 32'(mem_valid), 32'd0);
    check("overrun_wstrb_zero", 32'(mem_wstrb), 32'd0);
    check("overrun_cpu_held", 32'(cpu_resetn), 32'd0);
    check("overrun_not_done", 32'(load_done), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
